// File: rtl/axis_uart_rx_pkg.sv
// axis_uart_rx_pkg: shared UART receiver types, default widths and parity helper
// Contents: DATA_WIDTH / DIVIDER_WIDTH defaults, uart_state_e FSM states,
//           parity_bit() returning the expected parity bit for a data word.
package axis_uart_rx_pkg;
  localparam int DATA_WIDTH = 8;
  localparam int DIVIDER_WIDTH = 32;
  typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP, WAIT} uart_state_e;
  // Zero-extension to 64 bits leaves the reduction XOR unchanged, so any width up to 64 fits.
  function automatic logic parity_bit(input logic [63:0] data, input logic odd);
    return odd ? ~^data : ^data;
  endfunction
endpackage

// File: rtl/axis_uart_rx_if.sv
// axis_uart_rx_if: AXI-Stream byte channel from the UART receiver
// Signals: tdata (received word), tvalid (word available), tready (downstream accept).
// Modports: master drives tdata/tvalid, slave drives tready.
interface axis_uart_rx_if #(
  parameter int DATA_WIDTH = axis_uart_rx_pkg::DATA_WIDTH
);
  logic [DATA_WIDTH-1:0] tdata;
  logic tvalid;
  logic tready;
  modport master (output tdata, tvalid, input tready);
  modport slave (input tdata, tvalid, output tready);
endinterface

// File: rtl/axis_uart_rx_sync.sv
// uart_rx_sync: input flop chain for the serial line, reset to idle-high
// Ports: clk_i, rstn_i (sync active-low), rx_reset_i (sync active-high soft reset),
//        rx_i (raw line), rx_o (registered line).
// Macro UART_RX_SYNC_EN: defined -> 2-flop synchronizer, undefined -> single sampling flop.
module uart_rx_sync (
  input  logic clk_i,
  input  logic rstn_i,
  input  logic rx_reset_i,
  input  logic rx_i,
  output logic rx_o
);
`ifdef UART_RX_SYNC_EN
  logic [1:0] q;
  always_ff @(posedge clk_i) begin
    q <= (!rstn_i || rx_reset_i) ? 2'b11 : {q[0], rx_i};
  end
  assign rx_o = q[1];
`else
  logic q;
  always_ff @(posedge clk_i) begin
    q <= (!rstn_i || rx_reset_i) ? 1'b1 : rx_i;
  end
  assign rx_o = q;
`endif
endmodule

// File: rtl/axis_uart_rx.sv
// axis_uart_rx: UART receiver delivering bytes on an AXI-Stream master port
// Ports: clk_i, rstn_i (sync active-low reset), rx_reset_i (sync active-high soft reset),
//        clk_divider_i (clk_i cycles per bit, values below 4 act as 4),
//        parity_odd_i / parity_even_i (parity enables, odd wins),
//        uart_rx_i (serial line, idle high), m_axis (tdata/tvalid/tready),
//        parity_err_o / frame_err_o / overrun_o (one-cycle error pulses).
// Macro UART_RX_SYNC_EN: selects 2-flop line synchronizer instead of a single sampling flop.
module axis_uart_rx #(
  parameter int DATA_WIDTH = axis_uart_rx_pkg::DATA_WIDTH,
  parameter int DIVIDER_WIDTH = axis_uart_rx_pkg::DIVIDER_WIDTH
) (
  input  logic                     clk_i,
  input  logic                     rstn_i,
  input  logic                     rx_reset_i,
  input  logic [DIVIDER_WIDTH-1:0] clk_divider_i,
  input  logic                     parity_odd_i,
  input  logic                     parity_even_i,
  input  logic                     uart_rx_i,
  axis_uart_rx_if.master           m_axis,
  output logic                     parity_err_o,
  output logic                     frame_err_o,
  output logic                     overrun_o
);
  import axis_uart_rx_pkg::*;
  localparam logic [DIVIDER_WIDTH-1:0] ONE = DIVIDER_WIDTH'(1);
  localparam logic [DIVIDER_WIDTH-1:0] D_MIN = DIVIDER_WIDTH'(4);
  uart_state_e state, state_n;
  logic [DIVIDER_WIDTH-1:0] cnt, cnt_n, bit_cnt, bit_cnt_n, div, div_n, d_eff;
  logic [DATA_WIDTH-1:0] shreg, shreg_n, tdata, tdata_n;
  logic par_en, par_en_n, par_odd, par_odd_n, perr, perr_n;
  logic tvalid, tvalid_n, perr_p_n, ferr_p_n, ovr_p_n;
  logic rst, rx, rx_prev, tick, commit;

  assign rst = !rstn_i || rx_reset_i;
  assign d_eff = (clk_divider_i < D_MIN) ? D_MIN : clk_divider_i;
  assign tick = cnt == ONE;
  assign m_axis.tdata = tdata;
  assign m_axis.tvalid = tvalid;

  uart_rx_sync u_sync (
    .clk_i      (clk_i),
    .rstn_i     (rstn_i),
    .rx_reset_i (rx_reset_i),
    .rx_i       (uart_rx_i),
    .rx_o       (rx)
  );

  always_comb begin
    state_n = state;
    cnt_n = (cnt > ONE) ? cnt - ONE : cnt;
    bit_cnt_n = bit_cnt;
    div_n = div;
    par_en_n = par_en;
    par_odd_n = par_odd;
    perr_n = perr;
    shreg_n = shreg;
    commit = 1'b0;
    ferr_p_n = 1'b0;
    case (state)
      IDLE: if (rx_prev && !rx) begin
        state_n = START;
        cnt_n = d_eff >> 1;
        div_n = d_eff;
        par_en_n = parity_odd_i || parity_even_i;
        par_odd_n = parity_odd_i;
        bit_cnt_n = DIVIDER_WIDTH'(DATA_WIDTH);
        perr_n = 1'b0;
      end
      // A high mid-start sample means the falling edge was a glitch.
      START: if (tick) begin
        state_n = rx ? IDLE : DATA;
        cnt_n = rx ? '0 : div;
      end
      DATA: if (tick) begin
        shreg_n = {rx, shreg[DATA_WIDTH-1:1]};
        bit_cnt_n = bit_cnt - ONE;
        cnt_n = div;
        if (bit_cnt == ONE) state_n = par_en ? PARITY : STOP;
      end
      PARITY: if (tick) begin
        perr_n = rx != parity_bit(64'(shreg), par_odd);
        cnt_n = div;
        state_n = STOP;
      end
      STOP: if (tick) begin
        commit = rx;
        ferr_p_n = !rx;
        cnt_n = '0;
        state_n = rx ? IDLE : WAIT;
      end
      WAIT: if (rx) state_n = IDLE;
      default: state_n = IDLE;
    endcase
    // A held, unaccepted byte wins over a new commit; an accept in the commit cycle frees the slot.
    ovr_p_n = commit && tvalid && !m_axis.tready;
    tvalid_n = commit || (tvalid && !m_axis.tready);
    tdata_n = (commit && !ovr_p_n) ? shreg : tdata;
    perr_p_n = commit && perr;
  end

  always_ff @(posedge clk_i) begin
    if (rst) begin
      state <= IDLE;
      cnt <= '0;
      bit_cnt <= '0;
      div <= '0;
      par_en <= 1'b0;
      par_odd <= 1'b0;
      perr <= 1'b0;
      shreg <= '0;
      tdata <= '0;
      tvalid <= 1'b0;
      parity_err_o <= 1'b0;
      frame_err_o <= 1'b0;
      overrun_o <= 1'b0;
      rx_prev <= 1'b1;
    end else begin
      state <= state_n;
      cnt <= cnt_n;
      bit_cnt <= bit_cnt_n;
      div <= div_n;
      par_en <= par_en_n;
      par_odd <= par_odd_n;
      perr <= perr_n;
      shreg <= shreg_n;
      tdata <= tdata_n;
      tvalid <= tvalid_n;
      parity_err_o <= perr_p_n;
      frame_err_o <= ferr_p_n;
      overrun_o <= ovr_p_n;
      rx_prev <= rx;
    end
  end
endmodule

// File: tb/tb_axis_uart_rx.sv
// tb_axis_uart_rx: directed frames against an event-scheduled receiver model
module tb_axis_uart_rx;
`ifdef UART_RX_SYNC_EN
  localparam int LAT = 2;
`else
  localparam int LAT = 1;
`endif
  typedef struct {int cyc; bit commit; logic [7:0] data; bit perr;} ev_t;

  logic clk = 1'b0;
  always #5 clk = ~clk;
  logic rstn, rx_reset, par_odd, par_even, rx_line;
  logic [31:0] div;
  logic perr_o, ferr_o, ovr_o;
  axis_uart_rx_if #(.DATA_WIDTH(8)) axis ();

  axis_uart_rx dut (
    .clk_i         (clk),
    .rstn_i        (rstn),
    .rx_reset_i    (rx_reset),
    .clk_divider_i (div),
    .parity_odd_i  (par_odd),
    .parity_even_i (par_even),
    .uart_rx_i     (rx_line),
    .m_axis        (axis),
    .parity_err_o  (perr_o),
    .frame_err_o   (ferr_o),
    .overrun_o     (ovr_o)
  );

  int n_vec = 0, n_err = 0, cyc = 0, f_c0 = 0;
  bit chk_en = 0;
  ev_t evq[$];
  logic m_valid = 1'b0, m_perr = 1'b0, m_ferr = 1'b0, m_ovr = 1'b0;
  logic [7:0] m_data = 8'h00;

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h, expected %0h (cycle %0d)", nm, act, exp, cyc);
    end
  endtask

  // Model: each sent frame schedules its outcome at the edge where the registered
  // result appears: fall + line latency + half bit + full bits up to mid-stop + 1.
  initial forever begin
    logic old_v;
    @(posedge clk);
    cyc++;
    m_perr = 0;
    m_ferr = 0;
    m_ovr = 0;
    if (!rstn || rx_reset) begin
      m_valid = 0;
      m_data = 0;
      evq.delete();
    end else begin
      old_v = m_valid;
      if (old_v && axis.tready) m_valid = 0;
      for (int i = evq.size() - 1; i >= 0; i--) if (evq[i].cyc == cyc) begin
        if (evq[i].commit) begin
          m_perr = evq[i].perr;
          if (old_v && !axis.tready) m_ovr = 1;
          else begin
            m_valid = 1;
            m_data = evq[i].data;
          end
        end else m_ferr = 1;
        evq.delete(i);
      end
    end
  end

  initial forever begin
    @(negedge clk);
    if (chk_en) begin
      check("tvalid", axis.tvalid, m_valid);
      if (m_valid) check("tdata", axis.tdata, m_data);
      check("parity_err", perr_o, m_perr);
      check("frame_err", ferr_o, m_ferr);
      check("overrun", ovr_o, m_ovr);
    end
  end

  int n_rise = 0, hi_len = 0, rise_cyc = 0;
  logic [7:0] rise_data = 8'h00;
  logic seen_perr = 0, seen_ferr = 0, seen_ovr = 0, prev_v = 0;
  initial forever begin
    @(negedge clk);
    if (axis.tvalid === 1'b1 && prev_v !== 1'b1) begin
      n_rise++;
      rise_cyc = cyc;
      rise_data = axis.tdata;
      hi_len = 0;
    end
    if (axis.tvalid === 1'b1) hi_len++;
    seen_perr |= (perr_o === 1'b1);
    seen_ferr |= (ferr_o === 1'b1);
    seen_ovr |= (ovr_o === 1'b1);
    prev_v = axis.tvalid;
  end

  task automatic clr();
    n_rise = 0;
    hi_len = 0;
    rise_cyc = 0;
    rise_data = 0;
    seen_perr = 0;
    seen_ferr = 0;
    seen_ovr = 0;
  endtask

  task automatic idle(input int n);
    repeat (n) @(negedge clk);
  endtask

  // Called on a negedge; the start bit begins immediately.
  task automatic send_frame(input logic [7:0] data, input int d, input bit has_par,
                            input logic pbit, input logic stop, input bit disturb);
    int deff;
    logic exp_par, sodd;
    logic [31:0] sdiv;
    ev_t ev;
    deff = d < 4 ? 4 : d;
    f_c0 = cyc;
    exp_par = par_odd ? ~^data : ^data;
    ev.cyc = cyc + LAT + deff / 2 + deff * (9 + int'(has_par)) + 1;
    ev.commit = stop;
    ev.data = data;
    ev.perr = has_par && (pbit != exp_par);
    evq.push_back(ev);
    sdiv = div;
    sodd = par_odd;
    div = d;
    rx_line = 0;
    idle(deff);
    if (disturb) begin
      div = 32'd16;
      par_odd = 1;
    end
    for (int i = 0; i < 8; i++) begin
      rx_line = data[i];
      idle(deff);
    end
    if (has_par) begin
      rx_line = pbit;
      idle(deff);
    end
    rx_line = stop;
    idle(deff);
    div = sdiv;
    par_odd = sodd;
  endtask

  initial begin
    rstn = 0;
    rx_reset = 0;
    par_odd = 0;
    par_even = 0;
    rx_line = 1;
    div = 32'd16;
    axis.tready = 1;
    idle(3);
    chk_en = 1;
    check("rst_tvalid", axis.tvalid, 0);
    check("rst_tdata", axis.tdata, 8'h00);
    check("rst_perr", perr_o, 0);
    check("rst_ferr", ferr_o, 0);
    check("rst_ovr", ovr_o, 0);
    rstn = 1;
    idle(5);

    clr();
    send_frame(8'hA5, 16, 0, 0, 1, 0);
    idle(10);
    check("a5_latency", rise_cyc - f_c0, 153 + LAT);
    check("a5_data", rise_data, 8'hA5);
    check("a5_high_len", hi_len, 1);
    check("a5_count", n_rise, 1);

    par_odd = 1;
    clr();
    send_frame(8'h3C, 16, 1, 1, 1, 0);
    idle(10);
    check("par_ok_data", rise_data, 8'h3C);
    check("par_ok_err", seen_perr, 0);
    clr();
    send_frame(8'h3C, 16, 1, 0, 1, 0);
    idle(10);
    check("par_bad_data", rise_data, 8'h3C);
    check("par_bad_err", seen_perr, 1);
    par_even = 1;
    clr();
    send_frame(8'h3C, 16, 1, 1, 1, 0);
    idle(10);
    check("par_prio_err", seen_perr, 0);
    par_odd = 0;
    par_even = 0;

    clr();
    send_frame(8'h55, 16, 0, 0, 0, 0);
    idle(40);
    rx_line = 1;
    idle(20);
    check("ferr_seen", seen_ferr, 1);
    check("ferr_no_valid", n_rise, 0);
    clr();
    send_frame(8'h12, 16, 0, 0, 1, 0);
    idle(10);
    check("after_ferr_data", rise_data, 8'h12);
    check("after_ferr_count", n_rise, 1);

    axis.tready = 0;
    clr();
    send_frame(8'h11, 16, 0, 0, 1, 0);
    idle(5);
    send_frame(8'h22, 16, 0, 0, 1, 0);
    idle(10);
    check("ovr_seen", seen_ovr, 1);
    check("ovr_tdata_held", axis.tdata, 8'h11);
    check("ovr_tvalid_held", axis.tvalid, 1);
    axis.tready = 1;
    idle(1);
    check("ovr_accept_drop", axis.tvalid, 0);
    idle(5);

    clr();
    rx_line = 0;
    idle(4);
    rx_line = 1;
    idle(40);
    check("glitch_no_valid", n_rise, 0);
    check("glitch_no_err", {seen_perr, seen_ferr, seen_ovr}, 3'b000);

    clr();
    rx_line = 0;
    idle(16);
    rx_line = 1;
    idle(48);
    rx_reset = 1;
    idle(2);
    rx_reset = 0;
    idle(40);
    check("abort_no_valid", n_rise, 0);
    clr();
    send_frame(8'hF0, 16, 0, 0, 1, 0);
    idle(10);
    check("after_abort_data", rise_data, 8'hF0);
    check("after_abort_count", n_rise, 1);

    clr();
    send_frame(8'h5A, 3, 0, 0, 1, 1);
    idle(10);
    check("dmin_data", rise_data, 8'h5A);
    check("dmin_latency", rise_cyc - f_c0, 39 + LAT);
    check("dmin_no_err", {seen_perr, seen_ferr, seen_ovr}, 3'b000);

    idle(20);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule

// File: doc/axis_uart_rx.md
AXIS_UART_RX -- requirements
Module: axis_uart_rx

Interface
REQ-001 Parameter DATA_WIDTH, default 8: number of data bits per frame.
REQ-002 Parameter DIVIDER_WIDTH, default 32: width of the bit-period divider input.
REQ-003 The block SHALL use one clock and a synchronous, active-low reset, with ports as follows:
- clk_i, input, 1: single clock; all logic is on its rising edge.
- rstn_i, input, 1: reset, synchronous, active-low.
REQ-004 rx_reset_i, input, 1: soft reset, synchronous, active-high; same effect as rstn_i.
REQ-005 clk_divider_i, input, DIVIDER_WIDTH: clk_i cycles per bit (D).
REQ-006 parity_odd_i and parity_even_i, input, 1 each: parity enables; odd has priority.
REQ-007 uart_rx_i, input, 1: serial line, idle high.
REQ-008 m_axis_tdata, output, DATA_WIDTH: received byte.
REQ-009 m_axis_tvalid, output, 1: byte available.
REQ-010 m_axis_tready, input, 1: downstream accept.
REQ-011 parity_err_o, output, 1: one-cycle pulse on a parity mismatch.
REQ-012 frame_err_o, output, 1: one-cycle pulse when the stop bit is sampled low.
REQ-013 overrun_o, output, 1: one-cycle pulse when a byte is dropped.

Function
REQ-014 The FSM SHALL use the shared state enum with states IDLE, START, DATA, PARITY, STOP and WAIT.
REQ-015 IDLE: a high-to-low transition on the (synchronized) line SHALL move the FSM to START and load the bit counter.
REQ-016 START: after floor(D/2) cycles the line SHALL be sampled; low moves the FSM to DATA, high (a glitch) returns it to IDLE with no output.
REQ-017 DATA: a sample SHALL be taken every D cycles, DATA_WIDTH samples in total, LSB first, shifted into the data register; the FSM then moves to PARITY if either enable is set, else to STOP.
REQ-018 PARITY: the sample SHALL be taken after D cycles.
- Expected bit for odd parity is ~^data; for even parity it is ^data.
- A mismatch sets an internal error flag.
REQ-019 STOP: the sample SHALL be taken after D cycles.
- High: the FSM commits the byte and returns to IDLE.
- Low: frame_err_o pulses, the byte is discarded, and the FSM moves to WAIT.
REQ-020 WAIT: the FSM SHALL stay in WAIT until the line is sampled high, then return to IDLE.
REQ-021 Commit, output side:
- m_axis_tdata and m_axis_tvalid SHALL be registered and asserted on the cycle after the stop sample.
- parity_err_o pulses in that same cycle if the error flag is set; the byte is still delivered.
REQ-022 Commit, overrun: if m_axis_tvalid is already high and m_axis_tready is low at commit, the new byte SHALL be dropped, overrun_o pulses, and m_axis_tdata is unchanged.
REQ-023 Commit, simultaneous accept: if m_axis_tvalid and m_axis_tready are both high at commit, the new byte SHALL be loaded and m_axis_tvalid stays high (no overrun).
REQ-024 Handshake: m_axis_tvalid SHALL fall on the cycle after m_axis_tvalid && m_axis_tready unless a commit occurs in that same cycle; m_axis_tdata SHALL stay stable while m_axis_tvalid is high.
REQ-025 Divider: D values below 4 SHALL be treated as 4; D SHALL be latched on the start edge, so changing it mid-frame has no effect on that frame.
REQ-026 Parity enables SHALL also be latched on the start edge.
REQ-027 Counters SHALL be DIVIDER_WIDTH wide and count down to 1 without wrap-around.

Reset
REQ-028 On reset (rstn_i low or rx_reset_i high): FSM to IDLE, all counters 0, m_axis_tvalid 0, m_axis_tdata 0, all pulse outputs 0, synchronizer flops 1.
REQ-029 Reset mid-frame SHALL abort the frame with no output; a pending output byte is lost.

Configuration
REQ-030 With UART_RX_SYNC_EN defined, uart_rx_i SHALL pass through a 2-flop synchronizer (reset to 1), adding 2 cycles of latency.
REQ-031 Without UART_RX_SYNC_EN, the line SHALL be used through a single sampling flop only (1 cycle of latency).

Structure
REQ-032 uart_state_e, DATA_WIDTH, DIVIDER_WIDTH and the parity function SHALL come from the shared UART package; no local duplicates.
REQ-033 A sub-module uart_rx_sync SHALL implement the input flop chain, its depth selected by UART_RX_SYNC_EN.

Verification (D=16, no sync unless stated)
REQ-034 Frame 0xA5, 8N1, tready=1:
- m_axis_tdata=0xA5, m_axis_tvalid high for 1 cycle.
- tvalid rises 9.5*16+1=153 cycles after the line falling edge plus synchronizer latency.
REQ-035 Frame 0x3C with parity_odd_i=1 and parity bit 1:
- tdata=0x3C, parity_err_o=0.
- The same frame with parity bit 0 gives parity_err_o=1 and tdata=0x3C.
REQ-036 Frame 0x55 with stop bit forced low:
- frame_err_o pulses, no tvalid.
- Line held low 40 cycles, then high: the FSM returns to IDLE and the next frame 0x12 is received correctly.
REQ-037 tready=0, frames 0x11 then 0x22:
- Second commit gives overrun_o=1 and tdata stays 0x11.
- Raise tready: 0x11 is accepted, tvalid drops.
REQ-038 Line low pulse of 4 cycles: the glitch is rejected in START, with no output and no errors.
REQ-039 rx_reset_i asserted in DATA after 3 bits: the FSM goes to IDLE with no output; the next frame 0xF0 is received correctly, with UART_RX_SYNC_EN both defined and undefined.
